// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add unsigned multiplier (MUL / MLA / UMULL / UMLAL-low).
// One WIDTH-bit add with carry-out per cycle. An optional accumulate cycle adds a
// zero-extended operand to the 2*WIDTH-bit product.
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // The carry out of each add only lives in sum_c. After the right shift it
  // becomes bit WIDTH-1 of the partial high word, so the stored high word never
  // needs a 33rd bit.
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic             acc_en_q, acc_en_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             load_c;
  logic [WIDTH:0]   sum_c;
  logic [PW-1:0]    acc_sum_c;

  // A start is taken only when no operation is in flight.
  always_comb begin
    load_c = 1'b0;
    if (start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      load_c = 1'b1;
    end
  end

  // Shared adder: partial high word plus multiplicand, gated by the current multiplier bit.
  always_comb begin
    sum_c = {1'b0, phi_q};
    if (plo_q[0]) begin
      sum_c = {1'b0, phi_q} + {1'b0, mcand_q};
    end
  end

  // Accumulate step: 2*WIDTH-bit add; any overflow past the top bit is dropped.
  always_comb begin
    acc_sum_c = {phi_q, plo_q} + {WIDTH'(0), acc_q};
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    phi_d    = phi_q;
    plo_d    = plo_q;
    acc_en_d = acc_en_q;
    acc_d    = acc_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        phi_d   = sum_c[WIDTH:1];
        plo_d   = {sum_c[0], plo_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_COUNT) begin
          state_d = acc_en_q ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        phi_d   = acc_sum_c[PW-1:WIDTH];
        plo_d   = acc_sum_c[WIDTH-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = start ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_c) begin
      mcand_d  = a;
      phi_d    = '0;
      plo_d    = b;
      count_d  = '0;
      acc_en_d = acc_en;
      acc_d    = acc;
    end

    if ((state_d == S_RUN) || (state_d == S_ACC)) begin
      busy_d = 1'b1;
    end

    // Results are captured only on the edge that enters DONE.
    if (state_d == S_DONE) begin
      done_d   = 1'b1;
      res_hi_d = phi_d;
      res_lo_d = plo_d;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      phi_q    <= '0;
      plo_q    <= '0;
      acc_en_q <= 1'b0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      phi_q    <= phi_d;
      plo_q    <= plo_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors for mul_seq, checked every cycle against a
// cycle-count / arithmetic model plus hand-computed literal expectations.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        acc_en;
  logic [31:0] acc;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int checks = 0;
  int errors = 0;

  mul_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .acc_en    (acc_en),
    .acc       (acc),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an operation is just "cycles left" plus the arithmetic answer.
  int          m_left;
  logic        m_done;
  logic [63:0] m_res;
  logic [63:0] m_pending;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left    <= 0;
      m_done    <= 1'b0;
      m_res     <= 64'd0;
      m_pending <= 64'd0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pending;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_pending <= ({32'd0, a} * {32'd0, b}) + {32'd0, (acc_en ? acc : 32'd0)};
        m_left    <= acc_en ? 33 : 32;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_busy", 64'(busy), 64'(m_left > 0));
    chk("model_done", 64'(done), 64'(m_done));
    chk("model_result", {result_hi, result_lo}, m_res);
  end

  // Pulse start with operands, then count edges until done (bounded).
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb,
                       input logic ten, input logic [31:0] tacc);
    @(negedge clk);
    a = ta; b = tb; acc_en = ten; acc = tacc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
    end
  endtask

  int n;
  int busy_cnt;
  int done_cnt;

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0; acc_en = 1'b0; acc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", {result_hi, result_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 3 * 5, busy counted over the run
    issue(32'd3, 32'd5, 1'b0, 32'd0);
    busy_cnt = busy ? 1 : 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (busy) busy_cnt++;
    end
    chk("t1_latency", 64'(n), 64'd32);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd32);
    chk("t1_busy_in_done", 64'(busy), 64'd0);
    chk("t1_result", {result_hi, result_lo}, 64'h0000_0000_0000_000F);

    // all-ones squared
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    wait_done(n);
    chk("t2_latency", 64'(n), 64'd32);
    chk("t2_result", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

    // accumulate carry into high word
    issue(32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1);
    wait_done(n);
    chk("t3_latency", 64'(n), 64'd33);
    chk("t3_result", {result_hi, result_lo}, 64'h0000_0001_0000_0000);

    // start while busy is ignored
    issue(32'd7, 32'd6, 1'b0, 32'd0);
    done_cnt = 0;
    n = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 10) begin
        a = 32'd2; b = 32'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("t4_latency", 64'(n), 64'd32);
          chk("t4_result", {result_hi, result_lo}, 64'd42);
        end
      end
    end
    chk("t4_done_count", 64'(done_cnt), 64'd1);

    // back-to-back start in the DONE cycle
    issue(32'd5, 32'd5, 1'b0, 32'd0);
    wait_done(n);
    chk("t5a_result", {result_hi, result_lo}, 64'd25);
    chk("t5_done_seen", 64'(done), 64'd1);
    a = 32'h0001_0000; b = 32'h0001_0000; acc_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("t5_busy_no_idle", 64'(busy), 64'd1);
    chk("t5_result_held", {result_hi, result_lo}, 64'd25);
    wait_done(n);
    chk("t5_latency", 64'(n), 64'd32);
    chk("t5_result", {result_hi, result_lo}, 64'h0000_0001_0000_0000);

    // asynchronous reset mid-run
    issue(32'd9, 32'd9, 1'b0, 32'd0);
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_result", {result_hi, result_lo}, 64'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("t6_no_done", 64'(done_cnt), 64'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
